// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder with programmable wait states, byte-lane writes,
// a write-protected low region and the two-cycle ERROR response.
module ahb_sram_slave #(
  parameter int unsigned MEM_AW      = 8,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned WP_WORDS    = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic [1:0]  htrans,
  input  logic        hmastlock,
  input  logic        hready,
  input  logic [31:0] hwdata,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int unsigned DEPTH  = 1 << MEM_AW;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MEM_AW-1:0]   idx_q, idx_d;
  logic [3:0]          lanes_q, lanes_d;
  logic                write_q, write_d;
  logic                hreadyout_q, hreadyout_d;
  logic                hresp_q, hresp_d;
  logic [DATA_W-1:0]   hrdata_q, hrdata_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                accept_c;
  logic [MEM_AW-1:0]   idx_c;
  logic [3:0]          lanes_c;
  logic                size_err_c;
  logic                wp_err_c;
  logic                err_c;
  logic                commit_c;
  logic [DATA_W-1:0]   commit_word_c;
  logic [DATA_W-1:0]   rd_word_c;
  logic                unused_ok;

  assign unused_ok = ^{hburst, hprot, hmastlock, htrans[0], haddr[31:MEM_AW+2]};

  assign accept_c = hsel & hready & htrans[1];
  assign idx_c    = haddr[MEM_AW+1:2];

  // Address-phase decode: byte lanes and error classification
  always_comb begin
    lanes_c    = 4'b0000;
    size_err_c = 1'b0;
    case (hsize)
      3'd0: lanes_c = 4'b0001 << haddr[1:0];
      3'd1: begin
        lanes_c    = haddr[1] ? 4'b1100 : 4'b0011;
        size_err_c = haddr[0];
      end
      3'd2: begin
        lanes_c    = 4'b1111;
        size_err_c = |haddr[1:0];
      end
      default: size_err_c = 1'b1;
    endcase
    wp_err_c = hwrite && ((32'(idx_c) + 32'd1) <= WP_WORDS);
    err_c    = size_err_c | wp_err_c;
  end

  // A write lands on the edge that closes its DATA cycle
  assign commit_c = (state_q == S_DATA) && write_q;

  always_comb begin
    commit_word_c = mem_q[idx_q];
    for (int i = 0; i < 4; i++) begin
      if (lanes_q[i]) commit_word_c[8*i +: 8] = hwdata[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lanes_d = lanes_q;
    write_d = write_q;

    case (state_q)
      S_WAIT: begin
        if (cnt_q == CNT_W'(0)) state_d = S_DATA;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        if (accept_c) begin
          idx_d   = idx_c;
          lanes_d = lanes_c;
          write_d = hwrite;
          if (err_c) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES != 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase

    // Forward a same-edge commit so back-to-back write/read sees new data
    rd_word_c = (commit_c && (idx_q == idx_d)) ? commit_word_c : mem_q[idx_d];

    hreadyout_d = !((state_d == S_WAIT) || (state_d == S_ERR1));
    hresp_d     = (state_d == S_ERR1) || (state_d == S_ERR2);
    hrdata_d    = ((state_d == S_DATA) && !write_d) ? rd_word_c : '0;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      lanes_q     <= '0;
      write_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      lanes_q     <= lanes_d;
      write_q     <= write_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
    end
  end

  // Storage array, intentionally not reset
  always_ff @(posedge hclk) begin
    if (commit_c) mem_q[idx_q] <= commit_word_c;
  end

  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;
  assign hrdata    = hrdata_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench: bus A has one wait state and 4 protected words,
// bus B is zero-wait; a negedge monitor retires expected responses.
module tb_ahb_sram_slave;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel_a = 1'b0;
  logic        hsel_b = 1'b0;
  logic [31:0] haddr = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd2;
  logic [2:0]  hburst = 3'd0;
  logic [3:0]  hprot = 4'd0;
  logic [1:0]  htrans = 2'b00;
  logic        hmastlock = 1'b0;
  logic [31:0] hwdata = '0;

  logic        hreadyout_a, hresp_a, hreadyout_b, hresp_b;
  logic [31:0] hrdata_a, hrdata_b;

  always #5 hclk = ~hclk;

  ahb_sram_slave #(.MEM_AW(8), .WAIT_STATES(1), .WP_WORDS(4)) u_dut_a (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel_a), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hprot(hprot), .htrans(htrans),
    .hmastlock(hmastlock), .hready(hreadyout_a), .hwdata(hwdata),
    .hreadyout(hreadyout_a), .hresp(hresp_a), .hrdata(hrdata_a)
  );

  ahb_sram_slave #(.MEM_AW(8), .WAIT_STATES(0), .WP_WORDS(0)) u_dut_b (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel_b), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hprot(hprot), .htrans(htrans),
    .hmastlock(hmastlock), .hready(hreadyout_b), .hwdata(hwdata),
    .hreadyout(hreadyout_b), .hresp(hresp_b), .hrdata(hrdata_b)
  );

  typedef struct {
    int unsigned waits;
    logic        resp;
    logic        chk;
    logic [31:0] rdata;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  bit          pend[2];
  int unsigned wcnt[2];
  int          n_tests = 0;
  int          n_fail = 0;

  function automatic exp_t mk(input int unsigned w, input logic r, input logic c,
                              input logic [31:0] d);
    exp_t e;
    e.waits = w;
    e.resp  = r;
    e.chk   = c;
    e.rdata = d;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic monitor_bus(input int b);
    logic        sel, rdy, rsp;
    logic [31:0] rd;
    int          qsz;
    exp_t        e;
    sel = (b == 1) ? hsel_b : hsel_a;
    rdy = (b == 1) ? hreadyout_b : hreadyout_a;
    rsp = (b == 1) ? hresp_b : hresp_a;
    rd  = (b == 1) ? hrdata_b : hrdata_a;
    qsz = (b == 1) ? q_b.size() : q_a.size();
    if (hresetn !== 1'b1) begin
      pend[b] = 1'b0;
    end else begin
      if (pend[b]) begin
        if (qsz == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_xfer bus%0d: data phase with no expectation", b);
          pend[b] = 1'b0;
        end else begin
          e = (b == 1) ? q_b[0] : q_a[0];
          if (rdy) begin
            if (b == 1) void'(q_b.pop_front());
            else        void'(q_a.pop_front());
            check($sformatf("bus%0d_resp", b), 32'(rsp), 32'(e.resp));
            if (e.chk) check($sformatf("bus%0d_rdata", b), rd, e.rdata);
            check($sformatf("bus%0d_waits", b), 32'(wcnt[b]), 32'(e.waits));
            pend[b] = 1'b0;
          end else begin
            wcnt[b]++;
            check($sformatf("bus%0d_stall_resp", b), 32'(rsp), 32'(e.resp));
            check($sformatf("bus%0d_stall_rdata", b), rd, 32'h0);
          end
        end
      end
      if (sel && rdy && htrans[1]) begin
        pend[b] = 1'b1;
        wcnt[b] = 0;
      end
    end
  endtask

  always @(negedge hclk) begin
    for (int b = 0; b < 2; b++) monitor_bus(b);
  end

  // Non-pipelined transfer; expectation pushed at issue
  task automatic single(input bit b, input logic [31:0] addr, input bit wr,
                        input logic [2:0] size, input logic [31:0] wdata, input exp_t e);
    int guard;
    if (b) q_b.push_back(e);
    else   q_a.push_back(e);
    hsel_a = !b;
    hsel_b = b;
    haddr  = addr;
    hwrite = wr;
    hsize  = size;
    htrans = 2'b10;
    @(posedge hclk); #1;
    hsel_a = 1'b0;
    hsel_b = 1'b0;
    htrans = 2'b00;
    hwdata = wdata;
    guard  = 0;
    while (!(b ? hreadyout_b : hreadyout_a) && guard < 32) begin
      @(posedge hclk); #1;
      guard++;
    end
    if (guard >= 32) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout bus%0d addr %h: hreadyout stuck low", b, addr);
    end
    @(posedge hclk); #1;
  endtask

  initial begin
    logic [31:0] b_addr [10];
    logic        b_wr   [10];
    logic [31:0] b_data [10];
    int          guard;

    repeat (3) @(posedge hclk);
    #1;
    check("rst_hreadyout_a", 32'(hreadyout_a), 32'h1);
    check("rst_hresp_a",     32'(hresp_a),     32'h0);
    check("rst_hrdata_a",    hrdata_a,         32'h0);
    check("rst_hreadyout_b", 32'(hreadyout_b), 32'h1);
    hresetn = 1'b1;
    @(posedge hclk); #1;

    // Word write/read with one wait state
    single(0, 32'h10, 1, 3'd2, 32'hDEADBEEF, mk(1, 0, 1, 32'h0));
    single(0, 32'h10, 0, 3'd2, 32'h0,        mk(1, 0, 1, 32'hDEADBEEF));
    // Byte lane 1 write
    single(0, 32'h11, 1, 3'd0, 32'h0000AA00, mk(1, 0, 1, 32'h0));
    single(0, 32'h10, 0, 3'd2, 32'h0,        mk(1, 0, 1, 32'hDEADAAEF));
    // Misaligned halfword, misaligned word, bad size
    single(0, 32'h13, 1, 3'd1, 32'hFFFFFFFF, mk(1, 1, 1, 32'h0));
    single(0, 32'h10, 0, 3'd2, 32'h0,        mk(1, 0, 1, 32'hDEADAAEF));
    single(0, 32'h12, 0, 3'd2, 32'h0,        mk(1, 1, 1, 32'h0));
    single(0, 32'h10, 0, 3'd3, 32'h0,        mk(1, 1, 1, 32'h0));
    // Upper halfword write into word 5
    single(0, 32'h14, 1, 3'd2, 32'hCAFEF00D, mk(1, 0, 1, 32'h0));
    single(0, 32'h16, 1, 3'd1, 32'h12340000, mk(1, 0, 1, 32'h0));
    single(0, 32'h14, 0, 3'd2, 32'h0,        mk(1, 0, 1, 32'h1234F00D));
    single(0, 32'h14, 0, 3'd1, 32'h0,        mk(1, 0, 1, 32'h1234F00D));
    // Protected region: writes error, reads allowed
    single(0, 32'h08, 1, 3'd2, 32'h55555555, mk(1, 1, 1, 32'h0));
    single(0, 32'h0C, 1, 3'd0, 32'h55555555, mk(1, 1, 1, 32'h0));
    single(0, 32'h08, 0, 3'd2, 32'h0,        mk(1, 0, 0, 32'h0));

    // BUSY while selected and NONSEQ while deselected: no transfer
    hsel_a = 1'b1; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b01;
    @(posedge hclk); #1;
    hsel_a = 1'b0; htrans = 2'b10; hwdata = 32'hFFFFFFFF;
    check("busy_hreadyout", 32'(hreadyout_a), 32'h1);
    check("busy_hresp",     32'(hresp_a),     32'h0);
    @(posedge hclk); #1;
    htrans = 2'b00;
    check("nosel_hreadyout", 32'(hreadyout_a), 32'h1);
    @(posedge hclk); #1;
    single(0, 32'h10, 0, 3'd2, 32'h0, mk(1, 0, 1, 32'hDEADAAEF));

    // Zero-wait pipelined burst, then back-to-back write/read of one word
    b_addr = '{32'h20, 32'h24, 32'h28, 32'h2C, 32'h20, 32'h24, 32'h28, 32'h2C, 32'h40, 32'h40};
    b_wr   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    b_data = '{32'h01234567, 32'h89ABCDEF, 32'h13579BDF, 32'h2468ACE0,
               32'h01234567, 32'h89ABCDEF, 32'h13579BDF, 32'h2468ACE0,
               32'h5A5AC3C3, 32'h5A5AC3C3};
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) begin
        hsel_b = 1'b1;
        haddr  = b_addr[i];
        hwrite = b_wr[i];
        hsize  = 3'd2;
        htrans = (i == 0 || i == 4 || i == 8 || i == 9) ? 2'b10 : 2'b11;
        q_b.push_back(mk(0, 0, 1, b_wr[i] ? 32'h0 : b_data[i]));
      end else begin
        hsel_b = 1'b0;
        htrans = 2'b00;
      end
      hwdata = (i > 0 && b_wr[i-1]) ? b_data[i-1] : 32'h0;
      @(posedge hclk); #1;
    end
    @(posedge hclk); #1;

    // Reset during the wait state of a write
    single(0, 32'h30, 1, 3'd2, 32'h11111111, mk(1, 0, 1, 32'h0));
    hsel_a = 1'b1; haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
    @(posedge hclk); #1;
    hsel_a = 1'b0; htrans = 2'b00; hwdata = 32'h22222222;
    check("pre_reset_wait", 32'(hreadyout_a), 32'h0);
    hresetn = 1'b0;
    #1;
    check("midrst_hreadyout", 32'(hreadyout_a), 32'h1);
    check("midrst_hresp",     32'(hresp_a),     32'h0);
    check("midrst_hrdata",    hrdata_a,         32'h0);
    repeat (2) @(posedge hclk);
    #1;
    hresetn = 1'b1;
    @(posedge hclk); #1;
    single(0, 32'h30, 0, 3'd2, 32'h0,        mk(1, 0, 1, 32'h11111111));
    single(0, 32'h34, 1, 3'd2, 32'h0BADF00D, mk(1, 0, 1, 32'h0));
    single(0, 32'h34, 0, 3'd2, 32'h0,        mk(1, 0, 1, 32'h0BADF00D));

    guard = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && guard < 20) begin
      @(posedge hclk); #1;
      guard++;
    end
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d/%0d expectations never retired", q_a.size(), q_b.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
